// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and default geometry for the convolution window controller
// Contents: FSM state enum, default image/kernel parameters, counter-width helper.

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } conv_state_e;

  localparam int DEF_IMG_WIDTH  = 482;
  localparam int DEF_IMG_HEIGHT = 272;
  localparam int DEF_KSIZE      = 3;
  localparam int DEF_FLUSH_CYC  = 4;

  // clog2 with a floor of one bit so degenerate sizes still give a legal vector
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_COL_W = cnt_w(DEF_IMG_WIDTH);
  localparam int DEF_ROW_W = cnt_w(DEF_IMG_HEIGHT);

endpackage

// File: rtl/conv_pos_cnt.sv
// rtl/conv_pos_cnt.sv - pixel column/row position counter for one frame
// Ports: clk, rst_n (async, active-low); en advances one pixel; clr returns to (0,0)
//        and wins over en; col/row current position; line_end at the last column;
//        last_pix at the last pixel of the frame.

module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int COL_W      = DEF_COL_W,
  parameter int ROW_W      = DEF_ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             line_end,
  output logic             last_pix
);

  assign line_end = (col == COL_W'(IMG_WIDTH - 1));
  assign last_pix = line_end && (row == ROW_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      // Row never wraps inside a frame; the last pixel parks the counter at (0,0)
      if (last_pix) begin
        col <= '0;
        row <= '0;
      end else if (line_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - line-buffer sequencing controller for the KSIZE x KSIZE window
// Optional feature macro: CONV_CTRL_STAT_EN adds saturating frame_cnt / drop_cnt outputs.
// Ports: clk, rst_n (async, active-low); sof_in/pix_valid/pix_ready pixel handshake;
//        win_ready downstream backpressure; lb_wr_en/lb_rd_en per line buffer (0 = newest);
//        lb_clr FIFO clear during FLUSH; win_valid/win_row/win_col window centre (1-cycle
//        latency); eof last-window pulse; busy outside IDLE; sof_err sticky, err_clr clears.

module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KSIZE      = DEF_KSIZE,
  parameter int FLUSH_CYC  = DEF_FLUSH_CYC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sof_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic                         win_ready,
  output logic [KSIZE-2:0]             lb_wr_en,
  output logic [KSIZE-2:0]             lb_rd_en,
  output logic                         lb_clr,
  output logic                         win_valid,
  output logic [cnt_w(IMG_HEIGHT)-1:0] win_row,
  output logic [cnt_w(IMG_WIDTH)-1:0]  win_col,
  output logic                         eof,
  output logic                         busy,
  output logic                         sof_err,
  input  logic                         err_clr
`ifdef CONV_CTRL_STAT_EN
  ,
  output logic [15:0]                  frame_cnt,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam int FL_W  = cnt_w(FLUSH_CYC);
  localparam int HALF  = (KSIZE - 1) / 2;

  conv_state_e      state;
  logic [FL_W-1:0]  flush_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             line_end;
  logic             last_pix;
  logic             in_frame;
  logic             accept;
  logic             counted;
  logic             frame_err;
  logic             win_ok;

  assign in_frame  = (state == PRIME) || (state == RUN);
  assign pix_ready = (state == IDLE) || (state == PRIME) || ((state == RUN) && win_ready);
  assign accept    = pix_valid && pix_ready;
  // In IDLE only a sof beat starts a frame; inside a frame a sof beat is an error, not a pixel
  assign counted   = accept && (((state == IDLE) && sof_in) || (in_frame && !sof_in));
  assign frame_err = accept && in_frame && sof_in;
  assign win_ok    = (int'(row) >= KSIZE - 1) && (int'(col) >= KSIZE - 1);
  assign busy      = (state != IDLE);
  assign lb_clr    = (state == FLUSH);

  conv_pos_cnt #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (counted),
    .clr      (state == FLUSH),
    .col      (col),
    .row      (row),
    .line_end (line_end),
    .last_pix (last_pix)
  );

  // Each line buffer starts being read once it holds a full line; its output feeds the next one
  always_comb begin
    lb_rd_en = '0;
    lb_wr_en = '0;
    lb_wr_en[0] = counted;
    for (int i = 0; i < KSIZE - 1; i++) begin
      lb_rd_en[i] = counted && (int'(row) >= i + 1);
    end
    for (int i = 1; i < KSIZE - 1; i++) begin
      lb_wr_en[i] = lb_rd_en[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      eof       <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      win_valid <= counted && win_ok;
      eof       <= counted && last_pix;
      if (counted && win_ok) begin
        win_row <= row - ROW_W'(HALF);
        win_col <= col - COL_W'(HALF);
      end

      if (frame_err) begin
        sof_err <= 1'b1;
      end else if (err_clr) begin
        sof_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (counted) state <= PRIME;
        end
        PRIME: begin
          if (frame_err) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end else if (counted && line_end && (row == ROW_W'(KSIZE - 2))) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (frame_err || (counted && last_pix)) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_CTRL_STAT_EN
  logic drop_beat;
  assign drop_beat = accept && !counted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (eof && (frame_cnt != 16'hffff)) frame_cnt <= frame_cnt + 1'b1;
      if (drop_beat && (drop_cnt != 16'hffff)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - directed self-checking bench for conv_window_ctrl (8x6 image, 3x3 kernel)

module tb_conv_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int FC = 4;
  localparam int WPR = W - K + 1;  // windows per row

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof_in = 1'b0;
  logic pix_valid = 1'b0;
  logic win_ready = 1'b1;
  logic err_clr = 1'b0;
  logic pix_ready, lb_clr, win_valid, eof, busy, sof_err;
  logic [K-2:0] lb_wr_en, lb_rd_en;
  logic [2:0] win_row, win_col;
`ifdef CONV_CTRL_STAT_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  conv_window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .KSIZE      (K),
    .FLUSH_CYC  (FC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof_in    (sof_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_ready (win_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_rd_en  (lb_rd_en),
    .lb_clr    (lb_clr),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .eof       (eof),
    .busy      (busy),
    .sof_err   (sof_err),
    .err_clr   (err_clr)
`ifdef CONV_CTRL_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // monitor state
  logic [5:0] win_q[$];
  int win_cyc_q[$];
  int eof_n, clr_n;
  int eof_row, eof_col, eof_win;

  // driver state
  int first_rd0, first_rd1, wr0_n, wr1_n, rd1_n, en_n, ready_n;
  int acc_cyc, acc18_cyc;

  always @(negedge clk) begin
    if (win_valid) begin
      win_q.push_back({win_row, win_col});
      win_cyc_q.push_back(cyc_n);
    end
    if (eof) begin
      eof_n++;
      eof_row = int'(win_row);
      eof_col = int'(win_col);
      eof_win = int'(win_valid);
    end
    if (lb_clr) clr_n++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_stats();
    win_q.delete();
    win_cyc_q.delete();
    eof_n = 0; clr_n = 0; eof_row = -1; eof_col = -1; eof_win = 0;
    first_rd0 = -1; first_rd1 = -1;
    wr0_n = 0; wr1_n = 0; rd1_n = 0; en_n = 0; ready_n = 0;
    acc_cyc = 0; acc18_cyc = -1;
  endtask

  // Present one beat, hold it until pix_ready, capture the combinational enables, return
  // at the negedge after the accepting edge.
  task automatic send_pix(input bit sof, input int idx);
    int w;
    pix_valid = 1'b1;
    sof_in = sof;
    #1;
    w = 0;
    if (pix_ready) ready_n++;
    while (!pix_ready && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    if (!pix_ready) chk("accept_timeout", int'(pix_ready), 1);
    if (lb_wr_en != '0 || lb_rd_en != '0) en_n++;
    if (lb_rd_en[0] && first_rd0 < 0) first_rd0 = idx;
    if (lb_rd_en[1] && first_rd1 < 0) first_rd1 = idx;
    wr0_n += int'(lb_wr_en[0]);
    wr1_n += int'(lb_wr_en[1]);
    rd1_n += int'(lb_rd_en[1]);
    @(negedge clk);
    acc_cyc = cyc_n;
  endtask

  task automatic send_frame(input int err_at, input int stall_at);
    for (int i = 0; i < W * H; i++) begin
      if (i == stall_at) begin
        win_ready = 1'b0;
        pix_valid = 1'b1;
        sof_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_pix_ready", int'(pix_ready), 0);
          chk("stall_wr0", int'(lb_wr_en[0]), 0);
          @(negedge clk);
        end
        win_ready = 1'b1;
      end
      if (i == err_at) begin
        send_pix(1'b1, i);
        break;
      end
      send_pix(i == 0, i);
      if (i == 18) acc18_cyc = acc_cyc;
    end
    pix_valid = 1'b0;
    sof_in = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk); #1;
      w++;
    end while (busy && w < 40);
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic check_wins(input string tag, input int n_exp);
    int bad;
    logic [5:0] e;
    bad = 0;
    chk({tag, "_win_count"}, win_q.size(), n_exp);
    for (int j = 0; j < win_q.size() && j < n_exp; j++) begin
      e = {3'(1 + j / WPR), 3'(1 + j % WPR)};
      if (win_q[j] !== e) bad++;
    end
    chk({tag, "_win_seq_bad"}, bad, 0);
  endtask

  task automatic check_clean_frame(input string tag);
    check_wins(tag, 24);
    chk({tag, "_eof_n"}, eof_n, 1);
    chk({tag, "_eof_row"}, eof_row, 4);
    chk({tag, "_eof_col"}, eof_col, 6);
    chk({tag, "_clr_cycles"}, clr_n, FC);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_lb_clr", int'(lb_clr), 0);
    chk("rst_sof_err", int'(sof_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-sof beats in IDLE are taken and thrown away
    for (int i = 0; i < 5; i++) send_pix(1'b0, i);
    pix_valid = 1'b0;
    chk("idle_accepts", ready_n, 5);
    chk("idle_lb_en", en_n, 0);
    @(negedge clk); #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_wins", win_q.size(), 0);
`ifdef CONV_CTRL_STAT_EN
    chk("idle_drop_cnt", int'(drop_cnt), 5);
`endif

    // Frame 1: clean, enable timing
    clear_stats();
    send_frame(-1, -1);
    wait_idle();
    check_clean_frame("f1");
    chk("f1_first_win_cyc", win_cyc_q.size() > 0 ? win_cyc_q[0] : -1, acc18_cyc);
    chk("f1_eof_with_win", eof_win, 1);
    chk("f1_first_rd0", first_rd0, 8);
    chk("f1_first_rd1", first_rd1, 16);
    chk("f1_wr0_n", wr0_n, 48);
    chk("f1_wr1_n", wr1_n, 40);
    chk("f1_rd1_n", rd1_n, 32);
    chk("f1_sof_err", int'(sof_err), 0);

    // Frame 2: 3-cycle backpressure at pixel (3,4)
    clear_stats();
    send_frame(-1, 3 * W + 4);
    wait_idle();
    check_clean_frame("f2");

    // Frame 3: sof mid-frame at beat 20
    clear_stats();
    send_frame(20, -1);
    #1;
    chk("f3_sof_err", int'(sof_err), 1);
    chk("f3_busy_flush", int'(lb_clr), 1);
    wait_idle();
    chk("f3_eof_n", eof_n, 0);
    chk("f3_clr_cycles", clr_n, FC);
    check_wins("f3", 2);
    chk("f3_sof_err_held", int'(sof_err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("f3_err_clr", int'(sof_err), 0);

    // Frame 4: clean after the error
    clear_stats();
    send_frame(-1, -1);
    wait_idle();
    check_clean_frame("f4");
`ifdef CONV_CTRL_STAT_EN
    chk("f4_frame_cnt", int'(frame_cnt), 3);
    chk("f4_drop_cnt", int'(drop_cnt), 6);
`endif

    // Frame 5: async reset in RUN right after window (2,1)
    clear_stats();
    for (int i = 0; i < 27; i++) send_pix(i == 0, i);
    pix_valid = 1'b0;
    chk("pre_rst_win_valid", int'(win_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_win_valid", int'(win_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pix_ready", int'(pix_ready), 1);
    chk("mid_rst_lb_clr", int'(lb_clr), 0);
    chk("mid_rst_wr_en", int'(lb_wr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clear_stats();

    // Frame 6: clean after reset
    send_frame(-1, -1);
    wait_idle();
    check_clean_frame("f6");
`ifdef CONV_CTRL_STAT_EN
    chk("f6_frame_cnt", int'(frame_cnt), 1);
    chk("f6_drop_cnt", int'(drop_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
